// File: rtl/lib_mult_pipe_if.sv
// Operand/result handshake bundle for lib_mult_pipe.
// The multiplier is the slave; the producer/consumer side is the master.
interface lib_mult_pipe_if #(
  parameter int NA = 18,
  parameter int NB = 9,
  parameter int NO = 27
);
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [NA-1:0] a;
  logic [NB-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [NO-1:0] x;
  logic          x_sat;
  logic          x_signed;

  modport slave (
    input  in_valid, in_signed, a, b, out_ready,
    output in_ready, out_valid, x, x_sat, x_signed
  );

  modport master (
    output in_valid, in_signed, a, b, out_ready,
    input  in_ready, out_valid, x, x_sat, x_signed
  );
endinterface

// File: rtl/lib_mult_pipe.sv
// 3-stage signed/unsigned NAxNB multiplier with post-shift, optional rounding
// and saturation; valid/ready handshake with full backpressure.
module lib_mult_pipe #(
  parameter int NA    = 18,
  parameter int NB    = 9,
  parameter int SHIFT = 0,
  parameter int ROUND = 0,
  parameter int NO    = 27,
  parameter int SAT   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  lib_mult_pipe_if.slave bus
);
  localparam int STAGES = 3;
  localparam int NP     = NA + NB;
  localparam int RSH    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [NP:0] RND = (ROUND != 0 && SHIFT > 0) ? ((NP+1)'(1) << RSH) : '0;

  if (NO > NP || NO < 2 || SHIFT < 0 || SHIFT >= NP) begin : g_bad_param
    $error("lib_mult_pipe: illegal NO=%0d / SHIFT=%0d for NA=%0d NB=%0d", NO, SHIFT, NA, NB);
  end

  typedef struct packed {
    logic          sgn;
    logic          neg;
    logic [NA-1:0] abs_a;
    logic [NB-1:0] abs_b;
  } s1_t;

  typedef struct packed {
    logic          sgn;
    logic [NP-1:0] p;
  } s2_t;

  typedef struct packed {
    logic          sgn;
    logic          sat;
    logic [NO-1:0] x;
  } s3_t;

  logic [STAGES:1] vld_pipe;
  logic            adv1, adv2, in_rdy;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  s3_t             s3_d, s3_q;

  // Each stage frees up when its successor can take its contents.
  assign adv2   = !vld_pipe[3] || bus.out_ready;
  assign adv1   = !vld_pipe[2] || adv2;
  assign in_rdy = !vld_pipe[1] || adv1;

  // S1: sign/magnitude split; the most negative operand maps to 2^(N-1) exactly.
  always_comb begin
    s1_d       = '0;
    s1_d.sgn   = bus.in_signed;
    s1_d.neg   = bus.in_signed && (bus.a[NA-1] ^ bus.b[NB-1]);
    s1_d.abs_a = (bus.in_signed && bus.a[NA-1]) ? (~bus.a + NA'(1)) : bus.a;
    s1_d.abs_b = (bus.in_signed && bus.b[NB-1]) ? (~bus.b + NB'(1)) : bus.b;
  end

  // S2: unsigned magnitude product, sign re-applied.
  logic [NP-1:0] mag;
  always_comb begin
    mag      = NP'(s1_q.abs_a) * NP'(s1_q.abs_b);
    s2_d     = '0;
    s2_d.sgn = s1_q.sgn;
    s2_d.p   = s1_q.neg ? (~mag + NP'(1)) : mag;
  end

  // S3: one guard bit above the product keeps the rounding add from overflowing.
  logic [NP:0]        ext, sum, sh_u, sh;
  logic signed [NP:0] sh_s;
  logic               fit;
  logic [NO-1:0]      clip;
  always_comb begin
    ext  = {s2_q.sgn & s2_q.p[NP-1], s2_q.p};
    sum  = ext + RND;
    sh_s = $signed(sum) >>> SHIFT;
    sh_u = sum >> SHIFT;
    sh   = s2_q.sgn ? sh_s : sh_u;
    fit  = s2_q.sgn ? ((&sh[NP:NO-1]) | ~(|sh[NP:NO-1])) : ~(|sh[NP:NO]);
    clip = s2_q.sgn ? (sh[NP] ? {1'b1, {(NO-1){1'b0}}} : {1'b0, {(NO-1){1'b1}}})
                    : {NO{1'b1}};
    s3_d     = '0;
    s3_d.sgn = s2_q.sgn;
    s3_d.x   = sh[NO-1:0];
    if (SAT != 0 && !fit) begin
      s3_d.x   = clip;
      s3_d.sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else begin
      if (in_rdy) vld_pipe[1] <= bus.in_valid;
      if (adv1)   vld_pipe[2] <= vld_pipe[1];
      if (adv2)   vld_pipe[3] <= vld_pipe[2];
      if (in_rdy && bus.in_valid) s1_q <= s1_d;
      if (adv1 && vld_pipe[1])    s2_q <= s2_d;
      if (adv2 && vld_pipe[2])    s3_q <= s3_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_pipe[3];
  assign bus.x         = s3_q.x;
  assign bus.x_sat     = s3_q.sat;
  assign bus.x_signed  = s3_q.sgn;
endmodule

// File: doc/lib_mult_pipe.md
Name: lib_mult_pipe

Overview:
- Parametrised, pipelined successor to the library's combinational 18x9 signed multiplier. Width-generic.
- Per-transaction signed/unsigned mode.
- Post-multiply arithmetic right shift with optional round-half-up, and optional saturation to a narrower output.
- 3-stage pipeline with valid/ready handshake and full backpressure. Sits between datapath producers (filters, scalers) and accumulators in the libs tree.

Parameters:
- NA, 18, bit width of operand a.
- NB, 9, bit width of operand b.
- SHIFT, 0, arithmetic right shift applied to the full NA+NB product (0..NA+NB-1).
- ROUND, 0, 1 = round-half-up before the shift; 0 = truncate (floor). Ignored when SHIFT=0.
- NO, 27, output width. Must satisfy 2 <= NO <= NA+NB.
- SAT, 1, 1 = saturate to the NO-bit range; 0 = keep the low NO bits (wrap).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_signed  in  1  1 = a, b are two's complement; 0 = unsigned.
- a  in  NA  operand a.
- b  in  NB  operand b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- x  out  NO  result.
- x_sat  out  1  result was clipped (only when SAT=1; else 0).
- x_signed  out  1  mode of the beat carried with x.

Behaviour:
- Transfer rule: a beat transfers when valid && ready on the same rising edge.
- Stage 1 (S1), registered from the inputs:
  - abs_a = (in_signed && a[NA-1]) ? ~a+1 : a, held as NA-bit unsigned.
  - abs_b is formed the same way from b.
  - neg = in_signed && (a[NA-1] ^ b[NB-1]).
  - The mode bit is also registered.
  - Most-negative operand (e.g. -2^17) gives magnitude 2^17. This is exact in NA unsigned bits; no overflow.
- Stage 2 (S2):
  - mag = abs_a * abs_b, NA+NB bits unsigned.
  - p = neg ? ~mag+1 : mag, NA+NB bits.
  - The result is exact for all inputs: for defaults, (-2^17)*(-2^8) = +2^25 fits in 27-bit signed.
- Stage 3 (S3, output register):
  - If ROUND=1 and SHIFT>0, add 2^(SHIFT-1) to p in NA+NB+1 bits, then shift.
  - The shift is arithmetic in signed mode and logical in unsigned mode.
  - With SAT=1 and signed mode, clip to [-2^(NO-1), 2^(NO-1)-1].
  - With SAT=1 and unsigned mode, clip to [0, 2^NO-1].
  - x_sat = 1 when clipping occurred.
  - With SAT=0, x = low NO bits and x_sat = 0.
- Latency: 3 cycles, accept to out_valid, with no stall. Throughput is 1 beat/cycle.
- Backpressure:
  - Each stage has a valid bit.
  - Stage k loads when it is empty or its contents move forward this cycle.
  - S3 moves forward when out_ready=1.
  - in_ready = !v1 || advance1, where advance1 = !v2 || advance2, and advance2 = !v3 || out_ready.
  - Bubbles collapse: a stalled output with empty S1/S2 still accepts up to 2 more beats.
  - in_ready is combinational from out_ready.
- Output stability: while out_valid=1 and out_ready=0, x, x_sat and x_signed hold stable.
- Stage hold: data registers load only on stage advance. Stage data does not change while the stage holds.
- Reset:
  - rst_n low clears v1, v2 and v3 immediately (asynchronously) and zeroes all data registers.
  - Reset values: out_valid=0, x=0, x_sat=0, x_signed=0. in_ready reads 1 once reset is released.
  - Reset mid-stream discards all in-flight beats; nothing is replayed.
- Simultaneous accept and emit in the same cycle with a full pipe is legal and loses no beat.
- Parameter rule: NO > NA+NB is illegal. Elaboration must fail via a generate-time check.

Test Plan:
- Defaults, signed, out_ready=1: a=0x3FFFF (-1), b=0x1FF (-1) -> x=1 exactly 3 cycles after accept. a=0x20000, b=0x100 -> x=0x2000000, x_sat=0.
- Unsigned mode, defaults: a=0x3FFFF, b=0x1FF -> x=0x3FFFF*0x1FF=0x7FBFE01, x_signed=0. Same operands signed -> x=1.
- SHIFT=4, ROUND=1, NO=16, SAT=1, signed:
  - a=24, b=1 (p=24) -> x=2.
  - a=-24, b=1 -> x=-1 (0xFFFF).
  - a=0x1FFFF, b=0x0FF -> x=0x7FFF, x_sat=1.
  - Repeat with ROUND=0: 24 -> 1, -24 -> -2.
- Backpressure: stream 8 beats a=i, b=3 with out_ready=0 for cycles 4..9.
  - in_ready drops after 3 beats are held.
  - x, x_sat and x_signed stay stable while stalled.
  - All 8 results (0,3,..,21) arrive in order, with none lost or duplicated.
- Throughput: continuous in_valid with out_ready=1 for 100 random beats. One result per cycle after the 3-cycle fill; all results match the reference model in both modes.
- Reset mid-operation: assert rst_n=0 asynchronously (between edges) with 3 beats in flight.
  - out_valid and x go to 0 immediately.
  - After release, the first new beat a=5, b=7 yields x=35 with no stale output.
